// File: rtl/rgb_frame_streamer_pkg.sv
// Shared constants and FSM encoding for the RGB frame streamer and the conv blocks.
package rgb_frame_streamer_pkg;

   localparam int DEF_D          = 49;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic int frame_pixels(input int d);
      return d * d;
   endfunction

endpackage

// File: rtl/rgb_frame_streamer_if.sv
// Plane-memory read port plus the 3-channel pixel stream toward the conv merge block.
interface rgb_frame_streamer_if
   import rgb_frame_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data_1;
   logic [DATA_WIDTH-1:0] mem_data_2;
   logic [DATA_WIDTH-1:0] mem_data_3;
   logic                  valid_out_1;
   logic                  valid_out_2;
   logic                  valid_out_3;
   logic [DATA_WIDTH-1:0] pxl_out_1;
   logic [DATA_WIDTH-1:0] pxl_out_2;
   logic [DATA_WIDTH-1:0] pxl_out_3;

   modport master (
      output mem_rd_en, mem_addr,
      input  mem_data_1, mem_data_2, mem_data_3,
      output valid_out_1, valid_out_2, valid_out_3,
      output pxl_out_1, pxl_out_2, pxl_out_3
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output mem_data_1, mem_data_2, mem_data_3,
      input  valid_out_1, valid_out_2, valid_out_3,
      input  pxl_out_1, pxl_out_2, pxl_out_3
   );

endinterface

// File: rtl/rgb_frame_streamer_raster_addr_gen.sv
// Raster address counter 0..D*D-1 with enable, terminal-count flag and wrap to 0.
module raster_addr_gen
   import rgb_frame_streamer_pkg::*;
#(
   parameter int D          = DEF_D,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_en,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(frame_pixels(D) - 1);

   logic [ADDR_WIDTH-1:0] r_addr;

   // Full-width compare against T-1 so the counter never runs past the frame.
   assign o_last = (r_addr == LAST);
   assign o_addr = r_addr;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_addr <= '0;
      end else if (i_en) begin
         if (o_last) r_addr <= '0;
         else        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/rgb_frame_streamer.sv
// Streams one DxD frame per colour plane from three sync-read memories in raster order.
// Build option FRAME_REPEAT_EN: frames loop back-to-back until start is pressed again.
module rgb_frame_streamer
   import rgb_frame_streamer_pkg::*;
#(
   parameter int D          = DEF_D,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_pause,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_frame_cnt,
   rgb_frame_streamer_if.master bus
);
   state_t                r_state, w_state_nxt;
   logic                  w_issue, w_drained, w_fin, w_frame_end, w_stop;
   logic                  w_cnt_last;
   logic [ADDR_WIDTH-1:0] w_cnt;
   logic                  r_rd_en, r_v1, r_vout, r_busy, r_done;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [15:0]           r_frame_cnt;
   logic [DATA_WIDTH-1:0] r_pxl_1, r_pxl_2, r_pxl_3;

   raster_addr_gen #(.D(D), .ADDR_WIDTH(ADDR_WIDTH)) u_addr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (w_issue),
      .o_addr  (w_cnt),
      .o_last  (w_cnt_last)
   );

   assign w_drained = !r_rd_en && !r_v1;
   assign w_fin     = (r_state == S_DRAIN) && w_drained;

`ifdef FRAME_REPEAT_EN
   logic r_stop, r_last0, r_last1;

   // Second start while streaming requests a stop at the next frame boundary.
   assign w_stop      = r_stop || i_start;
   assign w_frame_end = r_v1 && r_last1;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_stop  <= 1'b0;
         r_last0 <= 1'b0;
         r_last1 <= 1'b0;
      end else begin
         if (r_state == S_IDLE)                    r_stop <= 1'b0;
         else if (r_state == S_FETCH && i_start)   r_stop <= 1'b1;
         r_last0 <= w_issue && w_cnt_last;
         r_last1 <= r_last0;
      end
   end
`else
   assign w_stop      = 1'b1;
   assign w_frame_end = w_fin;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (!i_pause) begin
               w_issue = 1'b1;
               if (w_cnt_last && w_stop) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: if (w_drained) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_rd_en     <= 1'b0;
         r_addr      <= '0;
         r_v1        <= 1'b0;
         r_vout      <= 1'b0;
         r_pxl_1     <= '0;
         r_pxl_2     <= '0;
         r_pxl_3     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rd_en <= w_issue;
         if (w_issue) r_addr <= w_cnt;
         r_v1    <= r_rd_en;
         r_vout  <= r_v1;
         // Pixel words only load on a real read so bubbles keep the last value.
         if (r_v1) begin
            r_pxl_1 <= bus.mem_data_1;
            r_pxl_2 <= bus.mem_data_2;
            r_pxl_3 <= bus.mem_data_3;
         end
         if (r_state == S_IDLE && i_start) r_busy <= 1'b1;
         else if (w_fin)                   r_busy <= 1'b0;
         r_done <= w_frame_end;
         if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign bus.mem_rd_en   = r_rd_en;
   assign bus.mem_addr    = r_addr;
   assign bus.valid_out_1 = r_vout;
   assign bus.valid_out_2 = r_vout;
   assign bus.valid_out_3 = r_vout;
   assign bus.pxl_out_1   = r_pxl_1;
   assign bus.pxl_out_2   = r_pxl_2;
   assign bus.pxl_out_3   = r_pxl_3;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_frame_cnt     = r_frame_cnt;

endmodule
